// File: rtl/cpu6_pipe_skid.sv
// rtl/cpu6_pipe_skid.sv - elastic main+skid pipeline register stage with registered ready
module cpu6_pipe_skid #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          i_valid,
  output logic          i_ready,
  input  logic [DW-1:0] i_data,
  output logic          o_valid,
  input  logic          o_ready,
  output logic [DW-1:0] o_data,
  output logic [1:0]    o_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] main_q, main_d;
  logic [DW-1:0] skid_q;
  logic          skid_ld;
  logic          valid_q, ready_q;
  logic [1:0]    count_q;

  // Next state and main-register load selection; flush wins over normal traffic.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_ld = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (i_valid) begin
            main_d  = i_data;
            state_d = BUSY;
          end
        end
        BUSY: begin
          // Both i_ready and o_valid are 1 here, so the raw handshakes are the transfers.
          if (i_valid && o_ready) begin
            main_d = i_data;
          end else if (i_valid) begin
            skid_ld = 1'b1;
            state_d = FULL;
          end else if (o_ready) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          // i_ready is 0, so i_data is ignored; only the downstream side moves.
          if (o_ready) begin
            main_d  = skid_q;
            state_d = BUSY;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // State, main payload and handshake outputs, all registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      count_q <= 2'd0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      valid_q <= (state_d != EMPTY);
      ready_q <= (state_d != FULL);
      case (state_d)
        BUSY:    count_q <= 2'd1;
        FULL:    count_q <= 2'd2;
        default: count_q <= 2'd0;
      endcase
    end
  end

  // Skid register is load-enable only; its contents are meaningless outside FULL.
  always_ff @(posedge clk) begin
    if (skid_ld && !rst) begin
      skid_q <= i_data;
    end
  end

  assign o_data  = main_q;
  assign o_valid = valid_q;
  assign i_ready = ready_q;
  assign o_count = count_q;

endmodule

// File: tb/tb_cpu6_pipe_skid.sv
// tb/tb_cpu6_pipe_skid.sv - table vectors plus scoreboarded random traffic for cpu6_pipe_skid
module tb_cpu6_pipe_skid;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst, flush, i_valid, i_ready, o_valid, o_ready;
  logic [DW-1:0] i_data, o_data;
  logic [1:0]    o_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cpu6_pipe_skid #(.DW(DW)) dut (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .i_data  (i_data),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_data  (o_data),
    .o_count (o_count)
  );

  typedef struct {
    logic        rst;
    logic        flush;
    logic        iv;
    logic        ordy;
    logic [31:0] d;
    logic        ov;
    logic        ir;
    logic [1:0]  cnt;
    logic [31:0] od;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic f, input logic iv, input logic ordy,
                     input logic [31:0] d, input logic ov, input logic ir,
                     input logic [1:0] cnt, input logic [31:0] od);
    vec_t v;
    v.rst = r; v.flush = f; v.iv = iv; v.ordy = ordy; v.d = d;
    v.ov = ov; v.ir = ir; v.cnt = cnt; v.od = od;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  logic [31:0] sb[$];
  logic [31:0] expd, prevd;
  logic        in_x, out_x, stall;

  initial begin
    //   rst flush iv ordy data          ov ir cnt o_data
    add(1, 0, 0, 0, 32'h0,          0, 1, 0, 32'h0);
    add(1, 0, 0, 0, 32'h0,          0, 1, 0, 32'h0);
    add(0, 0, 1, 1, 32'h11,         1, 1, 1, 32'h11);
    add(0, 0, 1, 1, 32'h22,         1, 1, 1, 32'h22);
    add(0, 0, 1, 1, 32'h33,         1, 1, 1, 32'h33);
    add(0, 0, 0, 1, 32'h0,          0, 1, 0, 32'h33);
    add(0, 0, 1, 0, 32'hA1,         1, 1, 1, 32'hA1);
    add(0, 0, 1, 0, 32'hA2,         1, 0, 2, 32'hA1);
    add(0, 0, 1, 0, 32'hA3,         1, 0, 2, 32'hA1);
    add(0, 0, 1, 0, 32'hA3,         1, 0, 2, 32'hA1);
    add(0, 0, 1, 0, 32'hA3,         1, 0, 2, 32'hA1);
    add(0, 0, 0, 1, 32'h0,          1, 1, 1, 32'hA2);
    add(0, 0, 0, 1, 32'h0,          0, 1, 0, 32'hA2);
    add(0, 0, 1, 0, 32'hB1,         1, 1, 1, 32'hB1);
    add(0, 0, 1, 0, 32'hB2,         1, 0, 2, 32'hB1);
    add(0, 1, 1, 0, 32'hFF,         0, 1, 0, 32'hB1);
    add(0, 0, 0, 0, 32'h0,          0, 1, 0, 32'hB1);
    add(0, 0, 1, 0, 32'h55,         1, 1, 1, 32'h55);
    add(1, 0, 1, 0, 32'h66,         0, 1, 0, 32'h0);
    add(0, 0, 0, 0, 32'h0,          0, 1, 0, 32'h0);
    add(0, 0, 1, 0, 32'h77,         1, 1, 1, 32'h77);
    add(0, 1, 1, 1, 32'h88,         0, 1, 0, 32'h77);
    add(0, 0, 1, 0, 32'hC1,         1, 1, 1, 32'hC1);
    add(0, 0, 1, 0, 32'hC2,         1, 0, 2, 32'hC1);
    add(0, 0, 1, 1, 32'hC3,         1, 1, 1, 32'hC2);
    add(0, 0, 0, 1, 32'h0,          0, 1, 0, 32'hC2);

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; flush = vecs[i].flush; i_valid = vecs[i].iv;
      o_ready = vecs[i].ordy; i_data = vecs[i].d;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_o_valid", i), o_valid, vecs[i].ov);
      check($sformatf("vec%0d_i_ready", i), i_ready, vecs[i].ir);
      check($sformatf("vec%0d_o_count", i), o_count, vecs[i].cnt);
      check($sformatf("vec%0d_o_data", i), o_data, vecs[i].od);
    end

    // Random traffic against an in-order FIFO model, starting from EMPTY.
    rst = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      i_valid = $urandom_range(0, 1);
      o_ready = $urandom_range(0, 1);
      i_data  = $urandom;
      flush   = ($urandom_range(0, 63) == 0);
      in_x  = i_valid & i_ready;
      out_x = o_valid & o_ready;
      if (out_x) begin
        if (sb.size() == 0) begin
          check("rand_underflow", 32'd1, 32'd0);
        end else begin
          expd = sb.pop_front();
          check("rand_data", o_data, expd);
        end
      end
      if (flush) sb.delete();
      else if (in_x) sb.push_back(i_data);
      stall = o_valid & ~o_ready;
      prevd = o_data;
      @(posedge clk);
      #1;
      check("rand_count", o_count, sb.size());
      check("rand_valid", o_valid, sb.size() != 0);
      check("rand_ready", i_ready, sb.size() != 2);
      if (stall && o_valid) check("rand_stable", o_data, prevd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
